// File: rtl/demux1an_param_condl1.sv
// demux1an_param_condl1: round-robin 1:LANES word demultiplexer for the receive path.
// MODE 0 presents each word on its own lane; MODE 1 stages a full lane group and presents it at once.
module demux1an_param_condl1 #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned LANES = 4,
  parameter  int unsigned MODE  = 0,
  localparam int unsigned PW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk_f,
  input  logic                   reset_L,
  input  logic                   valid_in,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   align,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic                   group_done,
  output logic [PW-1:0]          lane_ptr
);

  localparam logic [PW-1:0] LAST = PW'(LANES - 1);

  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          tgt;
  logic [LANES-1:0]       vld_q, vld_d;
  logic [LANES*WIDTH-1:0] data_q, data_d;
  logic                   done_q, done_d;

  // Lane the current word lands on: align forces lane 0 for this same word.
  always_comb begin
    tgt   = align ? '0 : ptr_q;
    ptr_d = ptr_q;
    if (valid_in) begin
      ptr_d = (tgt == LAST) ? '0 : tgt + PW'(1);
    end else if (align) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q  <= '0;
      vld_q  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  generate
    if (MODE == 0) begin : g_serial
      always_comb begin
        vld_d  = '0;
        data_d = data_q;
        done_d = 1'b0;
        if (valid_in) begin
          vld_d[tgt]                     = 1'b1;
          data_d[32'(tgt) * WIDTH +: WIDTH] = data_in;
          done_d                         = (tgt == LAST);
        end
      end
    end else begin : g_gather
      logic [WIDTH-1:0] stage_q [LANES];
      logic [WIDTH-1:0] stage_d [LANES];

      // The last-lane word is forwarded straight from data_in into the presented group.
      always_comb begin
        vld_d  = '0;
        data_d = data_q;
        done_d = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
          stage_d[k] = align ? '0 : stage_q[k];
        end
        if (valid_in) begin
          stage_d[tgt] = data_in;
          if (tgt == LAST) begin
            vld_d  = '1;
            done_d = 1'b1;
            for (int unsigned k = 0; k < LANES; k++) begin
              data_d[k*WIDTH +: WIDTH] = stage_d[k];
            end
          end
        end
      end

      always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            stage_q[k] <= '0;
          end
        end else begin
          for (int unsigned k = 0; k < LANES; k++) begin
            stage_q[k] <= stage_d[k];
          end
        end
      end
    end
  endgenerate

  assign valid_out  = vld_q;
  assign data_out   = data_q;
  assign group_done = done_q;
  assign lane_ptr   = ptr_q;

endmodule

// File: tb/tb_demux1an_param_condl1.sv
// Bench for demux1an_param_condl1: four configurations (serial/gather x 8b/4 lanes, 16b/3 lanes)
// share one stimulus stream and are compared against a word-count/queue reference model.
module tb_demux1an_param_condl1;

  logic        clk_f = 1'b0;
  logic        reset_L = 1'b1;
  logic        valid_in = 1'b0;
  logic        align = 1'b0;
  logic [15:0] din = '0;

  logic [3:0]  vo0, vo1;
  logic [31:0] do0, do1;
  logic        gd0, gd1;
  logic [1:0]  lp0, lp1;
  logic [2:0]  vo2, vo3;
  logic [47:0] do2, do3;
  logic        gd2, gd3;
  logic [1:0]  lp2, lp3;

  always #5 clk_f = ~clk_f;

  demux1an_param_condl1 #(.WIDTH(8), .LANES(4), .MODE(0)) dut0 (
    .clk_f(clk_f), .reset_L(reset_L), .valid_in(valid_in), .data_in(din[7:0]), .align(align),
    .valid_out(vo0), .data_out(do0), .group_done(gd0), .lane_ptr(lp0));
  demux1an_param_condl1 #(.WIDTH(8), .LANES(4), .MODE(1)) dut1 (
    .clk_f(clk_f), .reset_L(reset_L), .valid_in(valid_in), .data_in(din[7:0]), .align(align),
    .valid_out(vo1), .data_out(do1), .group_done(gd1), .lane_ptr(lp1));
  demux1an_param_condl1 #(.WIDTH(16), .LANES(3), .MODE(0)) dut2 (
    .clk_f(clk_f), .reset_L(reset_L), .valid_in(valid_in), .data_in(din), .align(align),
    .valid_out(vo2), .data_out(do2), .group_done(gd2), .lane_ptr(lp2));
  demux1an_param_condl1 #(.WIDTH(16), .LANES(3), .MODE(1)) dut3 (
    .clk_f(clk_f), .reset_L(reset_L), .valid_in(valid_in), .data_in(din), .align(align),
    .valid_out(vo3), .data_out(do3), .group_done(gd3), .lane_ptr(lp3));

  int cL [4] = '{4, 4, 3, 3};
  int cW [4] = '{8, 8, 16, 16};
  int cM [4] = '{0, 1, 0, 1};

  // Model: acc counts words since the last align/reset; gq holds the words of the group being built.
  int          acc [4];
  logic [15:0] ed  [4][4];
  logic [63:0] ev  [4];
  bit          edn [4];
  logic [15:0] gq  [4][$];

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input int c);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < cL[c]; k++) r = r | (64'(ed[c][k]) << (k * cW[c]));
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      acc[c] = 0;
      ev[c]  = '0;
      edn[c] = 1'b0;
      for (int k = 0; k < 4; k++) ed[c][k] = '0;
      gq[c].delete();
    end
  endtask

  task automatic model_step(input bit v, input bit al, input logic [15:0] d);
    logic [15:0] w;
    int lane;
    for (int c = 0; c < 4; c++) begin
      w      = (cW[c] == 8) ? (d & 16'h00FF) : d;
      ev[c]  = '0;
      edn[c] = 1'b0;
      if (al) begin
        acc[c] = 0;
        gq[c].delete();
      end
      if (v) begin
        lane   = acc[c] % cL[c];
        acc[c] = acc[c] + 1;
        if (cM[c] == 0) begin
          ev[c]       = 64'(1) << lane;
          ed[c][lane] = w;
          edn[c]      = (lane == cL[c] - 1);
        end else begin
          gq[c].push_back(w);
          if (gq[c].size() == cL[c]) begin
            for (int k = 0; k < cL[c]; k++) ed[c][k] = gq[c][k];
            ev[c]  = (64'(1) << cL[c]) - 64'(1);
            edn[c] = 1'b1;
            gq[c].delete();
          end
        end
      end
    end
  endtask

  task automatic check_dut(input int c, input logic [63:0] ov, input logic [63:0] od,
                           input logic og, input logic [63:0] op);
    chk($sformatf("d%0d_valid_out", c), ov, ev[c]);
    chk($sformatf("d%0d_data_out", c), od, exp_data(c));
    chk($sformatf("d%0d_group_done", c), 64'(og), 64'(edn[c]));
    chk($sformatf("d%0d_lane_ptr", c), op, 64'(acc[c] % cL[c]));
  endtask

  task automatic check_all();
    check_dut(0, 64'(vo0), 64'(do0), gd0, 64'(lp0));
    check_dut(1, 64'(vo1), 64'(do1), gd1, 64'(lp1));
    check_dut(2, 64'(vo2), 64'(do2), gd2, 64'(lp2));
    check_dut(3, 64'(vo3), 64'(do3), gd3, 64'(lp3));
  endtask

  task automatic cycle(input bit v, input bit al, input logic [15:0] d);
    valid_in = v;
    align    = al;
    din      = d;
    @(posedge clk_f);
    model_step(v, al, d);
    #1;
    check_all();
  endtask

  // Reset is dropped between edges; inputs stay busy to show they are ignored.
  task automatic do_reset(input int n);
    reset_L  = 1'b0;
    valid_in = 1'b1;
    align    = 1'b0;
    din      = 16'h00AA;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < n; i++) begin
      @(posedge clk_f);
      #1;
      check_all();
    end
    #3;
    reset_L = 1'b1;
  endtask

  initial begin
    #2;
    do_reset(3);

    // serial stream, 4 lanes wrap to lane 0
    cycle(1, 0, 16'h0010); chk("t2_vo_w0", 64'(vo0), 64'h1);
    cycle(1, 0, 16'h0011); chk("t2_vo_w1", 64'(vo0), 64'h2);
    cycle(1, 0, 16'h0012); chk("t2_vo_w2", 64'(vo0), 64'h4);
    cycle(1, 0, 16'h0013); chk("t2_vo_w3", 64'(vo0), 64'h8);
    chk("t2_done_w3", 64'(gd0), 64'h1);
    chk("t2_data_w3", 64'(do0), 64'h13121110);
    cycle(1, 0, 16'h0014); chk("t2_vo_w4", 64'(vo0), 64'h1);
    chk("t2_data_w4", 64'(do0), 64'h13121114);

    // gaps: data held, valid low while idle
    cycle(1, 1, 16'h0021);
    cycle(0, 0, 16'h00EE); chk("t3_vo_idle", 64'(vo0), 64'h0);
    cycle(0, 0, 16'h00EF); chk("t3_data_idle", 64'(do0), 64'h13121121);
    cycle(1, 0, 16'h0022); chk("t3_vo_w1", 64'(vo0), 64'h2);
    chk("t3_data_w1", 64'(do0), 64'h13122221);

    // align with and without a word
    cycle(1, 0, 16'h0031);
    cycle(1, 0, 16'h0032);
    cycle(1, 1, 16'h0033); chk("t4_ptr_align_v", 64'(lp0), 64'h1);
    chk("t4_data_align_v", 64'(do0), 64'h32312233);
    cycle(0, 1, 16'h0000); chk("t4_ptr_align_idle", 64'(lp0), 64'h0);

    // gather, back-to-back groups
    cycle(1, 1, 16'h5AA0);
    cycle(1, 0, 16'h5AA1);
    cycle(1, 0, 16'h5AA2);
    cycle(1, 0, 16'h5AA3); chk("t5_vo_a", 64'(vo1), 64'hF);
    chk("t5_data_a", 64'(do1), 64'hA3A2A1A0);
    chk("t5_done_a", 64'(gd1), 64'h1);
    cycle(1, 0, 16'h5BB0); chk("t5_vo_gap", 64'(vo1), 64'h0);
    cycle(1, 0, 16'h5BB1);
    cycle(1, 0, 16'h5BB2);
    cycle(1, 0, 16'h5BB3); chk("t5_data_b", 64'(do1), 64'hB3B2B1B0);

    // reset mid-group discards the partial group
    cycle(1, 1, 16'h00C0);
    cycle(1, 0, 16'h00C1);
    do_reset(1);
    cycle(1, 0, 16'h00D0);
    cycle(1, 0, 16'h00D1);
    cycle(1, 0, 16'h00D2);
    cycle(1, 0, 16'h00D3); chk("t6_data_new", 64'(do1), 64'hD3D2D1D0);
    chk("t6_vo_new", 64'(vo1), 64'hF);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 16'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
